// File: rtl/i2s_tx_serializer.sv
// i2s_tx_serializer: CS4272 I2S transmit path, clock generation plus stereo serializer; define I2S_TX_ZERO_ON_UNDERRUN_EN to send silence on underrun instead of repeating the last pair
module i2s_tx_serializer #(
   parameter int DATA_W = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              snd_vld,
   output logic              snd_rdy,
   input  logic [DATA_W-1:0] lft_in,
   input  logic [DATA_W-1:0] rht_in,
   output logic              MCLK,
   output logic              SCLK,
   output logic              LRCLK,
   output logic              SDin,
   output logic              frm_strt,
   output logic              underrun
);
   localparam int SLOT_W = 32;
   localparam int IW = $clog2(DATA_W);
   logic [10:0]       cnt, nxt;
   logic [DATA_W-1:0] hold_lft, hold_rht, shift_lft, shift_rht, sh;
   logic              full, load, sd_nxt;
   logic [4:0]        slot;
   logic [IW-1:0]     idx;
   // next-slot bit: slot 0 is the I2S delay bit, then MSB first, then zero pad
   always_comb begin
      nxt = cnt + 11'd1;
      load = cnt == 11'h7FF;
      slot = nxt[9:5];
      sh = nxt[10] ? shift_rht : shift_lft;
      idx = IW'(DATA_W - int'(slot));
      sd_nxt = (slot != 5'd0 && int'(slot) <= DATA_W) ? sh[idx] : 1'b0;
   end
   assign snd_rdy  = ~full;
   assign frm_strt = load & full;
   assign underrun = load & ~full;
   // codec clocks follow the next count so every edge lands with its cnt bit transition
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt   <= '0;
         MCLK  <= 1'b0;
         SCLK  <= 1'b0;
         LRCLK <= 1'b0;
      end else begin
         cnt   <= nxt;
         MCLK  <= nxt[1];
         SCLK  <= nxt[4];
         LRCLK <= nxt[10];
      end
   end
   // SDin changes together with the SCLK fall so it is stable at the rise
   always_ff @(posedge clk or posedge rst) begin
      if (rst) SDin <= 1'b0;
      else if (cnt[4:0] == 5'(SLOT_W - 1)) SDin <= sd_nxt;
   end
   // hold register fill and atomic frame load of both channels
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         hold_lft  <= '0;
         hold_rht  <= '0;
         shift_lft <= '0;
         shift_rht <= '0;
         full      <= 1'b0;
      end else begin
         if (snd_vld && !full) begin
            hold_lft <= lft_in;
            hold_rht <= rht_in;
            full     <= 1'b1;
         end
         if (load && full) begin
            shift_lft <= hold_lft;
            shift_rht <= hold_rht;
            full      <= 1'b0;
         end
`ifdef I2S_TX_ZERO_ON_UNDERRUN_EN
         else if (load) begin
            shift_lft <= '0;
            shift_rht <= '0;
         end
`endif
      end
   end
endmodule
